stack_burst_sequencer: RTL

// - Sequences multi-register PUSH/POP as a burst of single-word memory beats,
//   one beat per set bit of a 9-bit register list (bits 0-7 = R0-R7, bit 8 = LR on PUSH, PC on POP).
// - Sits between the decoder and the shared data-memory port.
// - Holds the core stalled (busy) for the burst; commits the new SP once at the end.

---
 rtl/stack_burst_sequencer_if.sv | 38 +++
 rtl/stack_burst_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/stack_burst_sequencer_if.sv
// Bundle of the decoder request, memory-port beat and core control signals
// used by stack_burst_sequencer. The slave modport is the sequencer's view.
// The master modport is the decoder/memory/core side.
interface stack_burst_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int RL_W   = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_pop;
  logic [RL_W-1:0]   req_rlist;
  logic [ADDR_W-1:0] sp_in;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [3:0]        reg_idx;
  logic              lr_sel;
  logic              rf_wr;
  logic              pc_wr;
  logic              sp_wr;
  logic [ADDR_W-1:0] sp_new;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  req_valid, req_pop, req_rlist, sp_in, mem_gnt,
    output req_ready, mem_req, mem_addr, mem_we, reg_idx, lr_sel,
           rf_wr, pc_wr, sp_wr, sp_new, busy, done, err
  );

  modport master (
    output req_valid, req_pop, req_rlist, sp_in, mem_gnt,
    input  req_ready, mem_req, mem_addr, mem_we, reg_idx, lr_sel,
           rf_wr, pc_wr, sp_wr, sp_new, busy, done, err
  );
endinterface

// File: rtl/stack_burst_sequencer.sv
// Multi-register PUSH/POP sequencer: turns a register list into a burst of
// single-word memory beats and commits the new SP once at the end.
// Optional macro SP_ALIGN_CHECK_EN: a misaligned sp_in aborts the burst
// with an err pulse instead of issuing beats.
module stack_burst_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int SP_STEP = 4,
  parameter int RL_W    = 9
) (
  input  logic                    clk,
  input  logic                    resetn,
  stack_burst_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_FIN} state_t;

  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(SP_STEP);
  localparam logic [3:0]        TOP_SLOT = 4'(RL_W - 1);
  localparam logic [RL_W-1:0]   ONE      = RL_W'(1);

  state_t            state_q, state_d;
  logic              pop_q, pop_d;
  logic [RL_W-1:0]   list_q, list_d;
  // PUSH: address of the previous beat (starts at sp_in); POP: next beat address.
  // Either way it equals the SP to commit once the list is drained.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              nonempty_q, nonempty_d;
  logic              err_q, err_d;

  logic [3:0]        slot;
  logic              misalign;

`ifdef SP_ALIGN_CHECK_EN
  assign misalign = (bus.sp_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Priority encoder: highest remaining slot for PUSH, lowest for POP.
  always_comb begin
    slot = 4'd0;
    if (pop_q) begin
      for (int i = RL_W - 1; i >= 0; i--)
        if (list_q[i]) slot = 4'(i);
    end else begin
      for (int i = 0; i < RL_W; i++)
        if (list_q[i]) slot = 4'(i);
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      pop_q      <= 1'b0;
      list_q     <= '0;
      addr_q     <= '0;
      nonempty_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop_q      <= pop_d;
      list_q     <= list_d;
      addr_q     <= addr_d;
      nonempty_q <= nonempty_d;
      err_q      <= err_d;
    end
  end

  // Next-state: accept in IDLE, retire one list bit per granted beat.
  always_comb begin
    state_d    = state_q;
    pop_d      = pop_q;
    list_d     = list_q;
    addr_d     = addr_q;
    nonempty_d = nonempty_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          pop_d      = bus.req_pop;
          list_d     = bus.req_rlist;
          addr_d     = bus.sp_in;
          nonempty_d = |bus.req_rlist;
          err_d      = misalign;
          if (misalign) begin
            list_d     = '0;
            nonempty_d = 1'b0;
            state_d    = S_FIN;
          end else if (|bus.req_rlist) begin
            state_d = S_BEAT;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_BEAT: begin
        if (bus.mem_gnt) begin
          list_d = list_q & ~(ONE << slot);
          addr_d = pop_q ? (addr_q + STEP) : (addr_q - STEP);
          if (list_d == '0) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d    = S_IDLE;
        list_d     = '0;
        nonempty_d = 1'b0;
        err_d      = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; beat fields are zero outside BEAT.
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.busy      = (state_q != S_IDLE);
    bus.mem_req   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.reg_idx   = 4'd0;
    bus.lr_sel    = 1'b0;
    bus.rf_wr     = 1'b0;
    bus.pc_wr     = 1'b0;
    bus.sp_wr     = 1'b0;
    bus.sp_new    = '0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    if (state_q == S_BEAT) begin
      bus.mem_req  = 1'b1;
      bus.mem_addr = pop_q ? addr_q : (addr_q - STEP);
      bus.mem_we   = ~pop_q;
      bus.reg_idx  = slot;
      bus.lr_sel   = ~pop_q & (slot == TOP_SLOT);
      bus.rf_wr    = pop_q & bus.mem_gnt & (slot != TOP_SLOT);
      bus.pc_wr    = pop_q & bus.mem_gnt & (slot == TOP_SLOT);
    end
    if (state_q == S_FIN) begin
      bus.done   = 1'b1;
      bus.sp_wr  = nonempty_q & ~err_q;
      bus.sp_new = addr_q;
`ifdef SP_ALIGN_CHECK_EN
      bus.err    = err_q;
`endif
    end
  end

endmodule
